morra_match_ctrl: RTL

Match-level sequencer for the Morra Cinese game core. It collects one move per player through valid/ready handshakes and starts the core with the configured game length. It issues move pairs, polls the core for end-of-game, and keeps a games scoreboard until one player reaches WINS_NEEDED or MAX_GAMES is exhausted. It sits between the player input front-ends and a single game-core instance.

---
 rtl/morra_match_ctrl_if.sv | 43 ++++
 rtl/morra_match_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/morra_match_ctrl_if.sv
// ---------------------------------------------------------------------------
// morra_match_ctrl_if
//
// Groups the two player move handshakes and the game-core command/result
// bus that surround the match controller.
//
//   P1_MOVE/P1_VALID/P1_READY   player-1 move handshake (2-bit move)
//   P2_MOVE/P2_VALID/P2_READY   player-2 move handshake (2-bit move)
//   CORE_START                  core start/config strobe
//   CORE_P1/CORE_P2             moves (or config code) driven to the core
//   CORE_ROUND                  core round result (00 null, 01 P1, 10 P2, 11 tie)
//   CORE_GAME                   core game result (00 running, 01 P1, 10 P2, 11 draw)
//
// Modports:
//   slave  - the match controller (consumes moves, drives the core)
//   master - the environment (players and game core)
// ---------------------------------------------------------------------------
interface morra_match_ctrl_if;

   logic [1:0] P1_MOVE;
   logic       P1_VALID;
   logic       P1_READY;
   logic [1:0] P2_MOVE;
   logic       P2_VALID;
   logic       P2_READY;

   logic       CORE_START;
   logic [1:0] CORE_P1;
   logic [1:0] CORE_P2;
   logic [1:0] CORE_ROUND;
   logic [1:0] CORE_GAME;

   modport slave (
      input  P1_MOVE, P1_VALID, P2_MOVE, P2_VALID, CORE_ROUND, CORE_GAME,
      output P1_READY, P2_READY, CORE_START, CORE_P1, CORE_P2
   );

   modport master (
      output P1_MOVE, P1_VALID, P2_MOVE, P2_VALID, CORE_ROUND, CORE_GAME,
      input  P1_READY, P2_READY, CORE_START, CORE_P1, CORE_P2
   );

endinterface

// File: rtl/morra_match_ctrl.sv
// ---------------------------------------------------------------------------
// morra_match_ctrl
//
// Match-level sequencer for the Morra Cinese game core. For each game it
// configures the core, then repeatedly collects one move per player, issues
// the pair, samples the round result, polls the core with a null pair and
// samples the game result. Finished games update a scoreboard until one
// player reaches WINS_NEEDED or MAX_GAMES games have been played.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   MATCH_GO        one-cycle match start request (ignored while BUSY)
//   CFG_LEN         game length code, sent on {CORE_P1,CORE_P2} at start
//   bus             player handshakes and core bus (slave modport)
//   LAST_ROUND      last round result sampled after a move pair
//   SCORE1/SCORE2   games won by player 1 / player 2
//   GAMES           games completed, draws included
//   MATCH_WINNER    00 none/in progress, 01 P1, 10 P2, 11 drawn match
//   BUSY            high while a match is in progress
//
// Parameters:
//   WINS_NEEDED     games needed to take the match
//   MAX_GAMES       games after which the match ends on score comparison
//   SCORE_W         width of the score/game counters
//   CORE_LAT        cycles (>= 1) from driving the core to a valid result
// ---------------------------------------------------------------------------
module morra_match_ctrl #(
   parameter int WINS_NEEDED = 2,
   parameter int MAX_GAMES   = 5,
   parameter int SCORE_W     = 3,
   parameter int CORE_LAT    = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 MATCH_GO,
   input  logic [3:0]           CFG_LEN,
   morra_match_ctrl_if.slave    bus,
   output logic [1:0]           LAST_ROUND,
   output logic [SCORE_W-1:0]   SCORE1,
   output logic [SCORE_W-1:0]   SCORE2,
   output logic [SCORE_W-1:0]   GAMES,
   output logic [1:0]           MATCH_WINNER,
   output logic                 BUSY
);

   localparam int                 LAT_W    = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
   localparam logic [LAT_W-1:0]   LAT_LAST = LAT_W'(CORE_LAT - 1);
   localparam logic [SCORE_W-1:0] WIN_TGT  = SCORE_W'(WINS_NEEDED);
   localparam logic [SCORE_W-1:0] GAME_TGT = SCORE_W'(MAX_GAMES);
   localparam logic [SCORE_W-1:0] CNT_MAX  = {SCORE_W{1'b1}};

   typedef enum logic [3:0] {
      IDLE,
      CFG,
      COLLECT,
      ISSUE,
      WAIT_R,
      POLL,
      WAIT_G,
      GAME_END,
      DONE
   } state_t;

   state_t             state;
   state_t             state_nx;

   // One-entry move buffer per player
   logic               full1;
   logic               full2;
   logic [1:0]         mv1;
   logic [1:0]         mv2;

   logic [LAT_W-1:0]   lat_cnt;
   logic [1:0]         game_res;

   logic               cap1;
   logic               cap2;
   logic               lat_done;
   logic               go_ok;

   logic [SCORE_W-1:0] score1_nx;
   logic [SCORE_W-1:0] score2_nx;
   logic [SCORE_W-1:0] games_nx;
   logic [1:0]         end_winner;

   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v,
                                                   input logic               en);
      if (en && (v != CNT_MAX)) begin
         return v + SCORE_W'(1);
      end
      return v;
   endfunction

   // ------------------------------------------------------------------------
   // Handshake and status decode
   // ------------------------------------------------------------------------
   assign bus.P1_READY = (state == COLLECT) && !full1;
   assign bus.P2_READY = (state == COLLECT) && !full2;
   assign cap1         = bus.P1_READY && bus.P1_VALID;
   assign cap2         = bus.P2_READY && bus.P2_VALID;

   assign lat_done     = (lat_cnt == LAT_LAST);
   assign go_ok        = ((state == IDLE) || (state == DONE)) && MATCH_GO;
   assign BUSY         = (state != IDLE) && (state != DONE);

   // ------------------------------------------------------------------------
   // Scoreboard update for the game result held in game_res. Only committed
   // in GAME_END; the end-of-match decision looks at the post-update values
   // so the winning game itself ends the match.
   // ------------------------------------------------------------------------
   always_comb begin
      score1_nx  = sat_inc(SCORE1, game_res == 2'b01);
      score2_nx  = sat_inc(SCORE2, game_res == 2'b10);
      games_nx   = sat_inc(GAMES, 1'b1);
      end_winner = 2'b00;
      if (score1_nx == WIN_TGT) begin
         end_winner = 2'b01;
      end else if (score2_nx == WIN_TGT) begin
         end_winner = 2'b10;
      end else if (games_nx == GAME_TGT) begin
         if (score1_nx > score2_nx) begin
            end_winner = 2'b01;
         end else if (score2_nx > score1_nx) begin
            end_winner = 2'b10;
         end else begin
            end_winner = 2'b11;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and core-bus outputs
   // ------------------------------------------------------------------------
   // NOTE: every signal this block writes gets a default first, so no path
   // leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_nx       = state;
      bus.CORE_START = 1'b0;
      bus.CORE_P1    = 2'b00;
      bus.CORE_P2    = 2'b00;

      case (state)
         IDLE, DONE: begin
            if (MATCH_GO) begin
               state_nx = CFG;
            end
         end

         CFG: begin
            bus.CORE_START             = 1'b1;
            {bus.CORE_P1, bus.CORE_P2} = CFG_LEN;
            state_nx                   = COLLECT;
         end

         COLLECT: begin
            // A capture this cycle counts as full, so ISSUE follows the
            // last capture directly.
            if ((full1 || cap1) && (full2 || cap2)) begin
               state_nx = ISSUE;
            end
         end

         ISSUE: begin
            bus.CORE_P1 = mv1;
            bus.CORE_P2 = mv2;
            state_nx    = WAIT_R;
         end

         WAIT_R: begin
            if (lat_done) begin
               state_nx = POLL;
            end
         end

         // Null pair: the core reports the game state without counting a round
         POLL: begin
            state_nx = WAIT_G;
         end

         WAIT_G: begin
            if (lat_done) begin
               state_nx = (bus.CORE_GAME == 2'b00) ? COLLECT : GAME_END;
            end
         end

         GAME_END: begin
            state_nx = (end_winner != 2'b00) ? DONE : CFG;
         end

         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State register, latency counter, move buffers and scoreboard
   // ------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         lat_cnt      <= '0;
         // NOTE: the move buffers are plain flops, not a RAM, so they are
         // reset with everything else; a reset mid-COLLECT must not leave a
         // stale move that would skip the next capture.
         full1        <= 1'b0;
         full2        <= 1'b0;
         mv1          <= 2'b00;
         mv2          <= 2'b00;
         game_res     <= 2'b00;
         LAST_ROUND   <= 2'b00;
         SCORE1       <= '0;
         SCORE2       <= '0;
         GAMES        <= '0;
         MATCH_WINNER <= 2'b00;
      end else begin
         state <= state_nx;

         // Counts the cycles spent in WAIT_R / WAIT_G; zero on entry.
         if (((state == WAIT_R) || (state == WAIT_G)) && !lat_done) begin
            lat_cnt <= lat_cnt + LAT_W'(1);
         end else begin
            lat_cnt <= '0;
         end

         if (cap1) begin
            full1 <= 1'b1;
            mv1   <= bus.P1_MOVE;
         end else if (state == ISSUE) begin
            full1 <= 1'b0;
            mv1   <= 2'b00;
         end

         if (cap2) begin
            full2 <= 1'b1;
            mv2   <= bus.P2_MOVE;
         end else if (state == ISSUE) begin
            full2 <= 1'b0;
            mv2   <= 2'b00;
         end

         if ((state == WAIT_R) && lat_done) begin
            LAST_ROUND <= bus.CORE_ROUND;
         end

         if ((state == WAIT_G) && lat_done) begin
            game_res <= bus.CORE_GAME;
         end

         if (go_ok) begin
            SCORE1       <= '0;
            SCORE2       <= '0;
            GAMES        <= '0;
            MATCH_WINNER <= 2'b00;
         end else if (state == GAME_END) begin
            SCORE1       <= score1_nx;
            SCORE2       <= score2_nx;
            GAMES        <= games_nx;
            MATCH_WINNER <= end_winner;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Structural properties
   // ------------------------------------------------------------------------
   a_start_only_in_cfg : assert property (@(posedge clk) disable iff (!rst_n)
      bus.CORE_START |-> (state == CFG));

   a_winner_only_when_done : assert property (@(posedge clk) disable iff (!rst_n)
      (MATCH_WINNER != 2'b00) |-> (state == DONE));

   a_buffers_empty_outside_collect : assert property (@(posedge clk) disable iff (!rst_n)
      ((state != COLLECT) && (state != ISSUE)) |-> (!full1 && !full2));

endmodule
